// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path.
package mips_pkg;

  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] ORI    = 6'h0D;
  localparam logic [5:0] ANDI   = 6'h0C;
  localparam logic [5:0] LUI    = 6'h0F;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] SW     = 6'h2B;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] BNE    = 6'h05;

  localparam logic [2:0] ALU_RTYPE = 3'b111;
  localparam logic [2:0] ALU_ADDI  = 3'b110;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_AND   = 3'b001;
  localparam logic [2:0] ALU_LUI   = 3'b011;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b100;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WR = 4'd7,
    S_WB_MEM = 4'd8,
    S_WB_ALU = 4'd9,
    S_BRANCH = 4'd10
  } state_t;

endpackage

// File: rtl/mc_out_decode.sv
// Combinational mapping of (state, opcode, mem_ready) to datapath controls.
module mc_out_decode
  import mips_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] OP,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       BranchEQ,
  output logic       BranchNE,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp,
  output logic       instr_done,
  output logic       illegal_op
);

  // Per-state control decode; anything not driven in a state stays 0.
  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemtoReg   = 1'b0;
    RegDst     = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    BranchEQ   = 1'b0;
    BranchNE   = 1'b0;
    ALUSrcB    = SRCB_REG;
    PCSource   = PCSRC_ALU;
    ALUOp      = 3'b000;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        ALUOp   = ALU_ADD;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        // Branch target is computed speculatively and latched into ALUOut.
        ALUSrcB = SRCB_IMMSH;
        ALUOp   = ALU_ADD;
        case (OP)
          R_TYPE, ADDI, ORI, ANDI, LUI, LW, SW, BEQ, BNE: illegal_op = 1'b0;
          default: illegal_op = 1'b1;
        endcase
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_REG;
        ALUOp   = ALU_RTYPE;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        case (OP)
          ORI:     ALUOp = ALU_OR;
          ANDI:    ALUOp = ALU_AND;
          LUI:     ALUOp = ALU_LUI;
          default: ALUOp = ALU_ADDI;
        endcase
      end
      S_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALU_ADD;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      S_WB_MEM: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_WB_ALU: begin
        RegWrite   = 1'b1;
        RegDst     = (OP == R_TYPE);
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_REG;
        ALUOp      = ALU_SUB;
        PCSource   = PCSRC_ALUOUT;
        BranchEQ   = (OP == BEQ);
        BranchNE   = (OP == BNE);
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: state register and next-state logic.
//   state    | meaning
//   IDLE     | after reset, outputs quiet
//   FETCH    | read instruction, PC+4, wait for mem_ready
//   DECODE   | register read, branch target into ALUOut
//   EXEC_R   | R-type ALU operation
//   EXEC_I   | immediate ALU operation
//   ADDR     | load/store address computation
//   MEM_RD   | data read, wait for mem_ready
//   MEM_WR   | data write, wait for mem_ready, retires SW
//   WB_MEM   | load data to register file
//   WB_ALU   | ALU result to register file
//   BRANCH   | compare and conditional PC update
module multicycle_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       BranchEQ,
  output logic       BranchNE,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp,
  output logic       instr_done,
  output logic       illegal_op
);

  state_t state;
  state_t state_nxt;

  // State register; async reset parks in IDLE where every control is 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state sequencing; mem_ready only matters in the memory-access states.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (OP)
          R_TYPE:               state_nxt = S_EXEC_R;
          ADDI, ORI, ANDI, LUI: state_nxt = S_EXEC_I;
          LW, SW:               state_nxt = S_ADDR;
          BEQ, BNE:             state_nxt = S_BRANCH;
          default:              state_nxt = S_FETCH;
        endcase
      end
      S_EXEC_R: state_nxt = S_WB_ALU;
      S_EXEC_I: state_nxt = S_WB_ALU;
      S_ADDR:   state_nxt = (OP == SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (mem_ready) state_nxt = S_WB_MEM;
      S_MEM_WR: if (mem_ready) state_nxt = S_FETCH;
      S_WB_MEM: state_nxt = S_FETCH;
      S_WB_ALU: state_nxt = S_FETCH;
      S_BRANCH: state_nxt = S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
  end

  mc_out_decode u_out_decode (
    .state      (state),
    .OP         (OP),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg),
    .RegDst     (RegDst),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .BranchEQ   (BranchEQ),
    .BranchNE   (BranchNE),
    .ALUSrcB    (ALUSrcB),
    .PCSource   (PCSource),
    .ALUOp      (ALUOp),
    .instr_done (instr_done),
    .illegal_op (illegal_op)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes the expected
// control word per cycle, a negedge monitor pops and compares.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OP;
  logic       mem_ready;
  logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg;
  logic       RegDst, RegWrite, ALUSrcA, BranchEQ, BranchNE;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic       instr_done, illegal_op;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [19:0] exp;
    string       name;
  } sb_item_t;

  sb_item_t sb_q[$];

  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .OP         (OP),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg),
    .RegDst     (RegDst),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .BranchEQ   (BranchEQ),
    .BranchNE   (BranchNE),
    .ALUSrcB    (ALUSrcB),
    .PCSource   (PCSource),
    .ALUOp      (ALUOp),
    .instr_done (instr_done),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  logic [19:0] got;
  assign got = {PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegDst,
                RegWrite, ALUSrcA, BranchEQ, BranchNE, ALUSrcB, PCSource,
                ALUOp, instr_done, illegal_op};

  function automatic logic [19:0] v(
    input logic pcw, irw, iord, mrd, mwr, m2r, rdst, rw, srca, beq, bne,
    input logic [1:0] srcb, input logic [1:0] pcs, input logic [2:0] aop,
    input logic done, ill);
    return {pcw, irw, iord, mrd, mwr, m2r, rdst, rw, srca, beq, bne,
            srcb, pcs, aop, done, ill};
  endfunction

  //                  pcw irw iord mrd mwr m2r rdst rw srca beq bne srcb   pcs    aop    done ill
  localparam logic [19:0] ZERO = 20'h0;
  logic [19:0] F1, F0, DEC, DEC_ILL, EXR, ADR, MRD, MWR0, MWR1, WBM, WBR, WBI, BRNE, BREQ;

  initial begin
    F1      = v(1,1,0,1,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0,0);
    F0      = v(0,0,0,1,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0,0);
    DEC     = v(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,0);
    DEC_ILL = v(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,1);
    EXR     = v(0,0,0,0,0,0,0,0,1,0,0,2'b00,2'b00,3'b111,0,0);
    ADR     = v(0,0,0,0,0,0,0,0,1,0,0,2'b10,2'b00,3'b010,0,0);
    MRD     = v(0,0,1,1,0,0,0,0,0,0,0,2'b00,2'b00,3'b000,0,0);
    MWR0    = v(0,0,1,0,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0,0);
    MWR1    = v(0,0,1,0,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,1,0);
    WBM     = v(0,0,0,0,0,1,0,1,0,0,0,2'b00,2'b00,3'b000,1,0);
    WBR     = v(0,0,0,0,0,0,1,1,0,0,0,2'b00,2'b00,3'b000,1,0);
    WBI     = v(0,0,0,0,0,0,0,1,0,0,0,2'b00,2'b00,3'b000,1,0);
    BRNE    = v(0,0,0,0,0,0,0,0,1,0,1,2'b00,2'b01,3'b100,1,0);
    BREQ    = v(0,0,0,0,0,0,0,0,1,1,0,2'b00,2'b01,3'b100,1,0);
  end

  function automatic logic [19:0] exec_i(input logic [2:0] aop);
    return v(0,0,0,0,0,0,0,0,1,0,0,2'b10,2'b00,aop,0,0);
  endfunction

  // One bench cycle: drive just after the rising edge, queue the expected word.
  task automatic cyc(input string nm, input logic rst, input logic [5:0] op,
                     input logic rdy, input logic [19:0] e);
    sb_item_t it;
    @(posedge clk);
    #1;
    reset     = rst;
    OP        = op;
    mem_ready = rdy;
    it.exp  = e;
    it.name = nm;
    sb_q.push_back(it);
  endtask

  // Monitor: compare whatever the DUT presents mid-cycle against the scoreboard head.
  always @(negedge clk) begin
    sb_item_t it;
    if (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      checks++;
      if (got !== it.exp) begin
        errors++;
        $display("FAIL %s: got %05h required %05h", it.name, got, it.exp);
      end
      if (instr_done === 1'b1 && illegal_op === 1'b1) begin
        errors++;
        $display("FAIL %s: instr_done and illegal_op both high", it.name);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, queue depth %0d required 0", sb_q.size());
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [5:0] op;
    logic [2:0] aop;
    string      nm;
  } itype_t;

  initial begin
    itype_t itab[4];
    itab[0] = '{6'h0F, 3'b011, "lui_exec"};
    itab[1] = '{6'h08, 3'b110, "addi_exec"};
    itab[2] = '{6'h0D, 3'b101, "ori_exec"};
    itab[3] = '{6'h0C, 3'b001, "andi_exec"};

    reset = 1'b0; OP = 6'h00; mem_ready = 1'b1;

    for (int i = 0; i < 3; i++) cyc("reset_hold", 1'b0, 6'h00, 1'b1, ZERO);
    cyc("idle", 1'b1, 6'h00, 1'b1, ZERO);

    // R-type; mem_ready low outside FETCH must not stall
    cyc("r_fetch",  1'b1, 6'h00, 1'b1, F1);
    cyc("r_decode", 1'b1, 6'h00, 1'b0, DEC);
    cyc("r_exec",   1'b1, 6'h00, 1'b0, EXR);
    cyc("r_wb",     1'b1, 6'h00, 1'b0, WBR);

    // LW with two wait cycles in MEM_RD
    cyc("lw_fetch",  1'b1, 6'h23, 1'b1, F1);
    cyc("lw_decode", 1'b1, 6'h23, 1'b1, DEC);
    cyc("lw_addr",   1'b1, 6'h23, 1'b1, ADR);
    cyc("lw_mrd0",   1'b1, 6'h23, 1'b0, MRD);
    cyc("lw_mrd1",   1'b1, 6'h23, 1'b0, MRD);
    cyc("lw_mrd2",   1'b1, 6'h23, 1'b1, MRD);
    cyc("lw_wb",     1'b1, 6'h23, 1'b1, WBM);

    // BNE with one FETCH stall cycle
    cyc("bne_fetch_wait", 1'b1, 6'h05, 1'b0, F0);
    cyc("bne_fetch",      1'b1, 6'h05, 1'b1, F1);
    cyc("bne_decode",     1'b1, 6'h05, 1'b1, DEC);
    cyc("bne_branch",     1'b1, 6'h05, 1'b1, BRNE);

    cyc("beq_fetch",  1'b1, 6'h04, 1'b1, F1);
    cyc("beq_decode", 1'b1, 6'h04, 1'b1, DEC);
    cyc("beq_branch", 1'b1, 6'h04, 1'b1, BREQ);

    cyc("ill_fetch",  1'b1, 6'h3F, 1'b1, F1);
    cyc("ill_decode", 1'b1, 6'h3F, 1'b1, DEC_ILL);

    foreach (itab[k]) begin
      cyc("i_fetch",  1'b1, itab[k].op, 1'b1, F1);
      cyc("i_decode", 1'b1, itab[k].op, 1'b1, DEC);
      cyc(itab[k].nm, 1'b1, itab[k].op, 1'b1, exec_i(itab[k].aop));
      cyc("i_wb",     1'b1, itab[k].op, 1'b1, WBI);
    end

    cyc("sw_fetch",  1'b1, 6'h2B, 1'b1, F1);
    cyc("sw_decode", 1'b1, 6'h2B, 1'b1, DEC);
    cyc("sw_addr",   1'b1, 6'h2B, 1'b1, ADR);
    cyc("sw_mwr",    1'b1, 6'h2B, 1'b1, MWR1);

    // SW stalled in MEM_WR, then reset asserted mid-cycle
    cyc("sw2_fetch",  1'b1, 6'h2B, 1'b1, F1);
    cyc("sw2_decode", 1'b1, 6'h2B, 1'b1, DEC);
    cyc("sw2_addr",   1'b1, 6'h2B, 1'b1, ADR);
    cyc("sw2_mwr",    1'b1, 6'h2B, 1'b0, MWR0);
    cyc("sw2_async_reset", 1'b0, 6'h2B, 1'b0, ZERO);
    cyc("sw2_reset_hold",  1'b0, 6'h2B, 1'b1, ZERO);
    cyc("post_reset_idle", 1'b1, 6'h00, 1'b1, ZERO);
    cyc("post_reset_fetch", 1'b1, 6'h00, 1'b1, F1);

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: depth %0d required 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style sequencing FSM for the multi-cycle MIPS datapath. It replaces single-cycle opcode decoding by stepping each instruction through fetch, decode, execute, memory and write-back states, and stalls on a shared memory port's ready signal. It drives the datapath's enable, select and ALU-operation controls. It supports R-type, ADDI, ORI, ANDI, LUI, LW, SW, BEQ and BNE.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low.
- OP  in  6  opcode, IR[31:26]; stable outside FETCH because the IR only loads in FETCH.
- mem_ready  in  1  shared instruction/data memory has completed the current access this cycle.
- PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  out  1 each  datapath controls.
- BranchEQ, BranchNE  out  1 each  enable a PC write when the ALU result is zero or non-zero.
- ALUSrcB  out  2  ALU operand B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- PCSource  out  2  PC source select: 00 = ALU result, 01 = ALUOut.
- ALUOp  out  3  ALU operation code: 111 = R-type (funct field), 110 = add-immediate, 101 = or, 001 = and, 011 = LUI, 010 = add, 100 = subtract.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode.

## Operation
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_MEM, WB_ALU, BRANCH. 4-bit encoding.
- Any control not listed for a state is 0.
- IDLE: all outputs 0. Always goes to FETCH on the next edge.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=010, PCSource=00.
  - IRWrite and PCWrite equal mem_ready.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=010, so the branch target is latched into ALUOut. Next state by OP:
  - 0x00 → EXEC_R.
  - 0x08, 0x0D, 0x0C, 0x0F → EXEC_I.
  - 0x23, 0x2B → ADDR.
  - 0x04, 0x05 → BRANCH.
  - Any other opcode → FETCH, with illegal_op=1 in this DECODE cycle.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=111. Goes to WB_ALU.
- EXEC_I: ALUSrcA=1, ALUSrcB=10. ALUOp is 110 (ADDI), 101 (ORI), 001 (ANDI) or 011 (LUI). Goes to WB_ALU.
- ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=010. Goes to MEM_RD for LW, MEM_WR for SW.
- MEM_RD: MemRead=1, IorD=1. Holds until mem_ready=1, then goes to WB_MEM.
- MEM_WR: MemWrite=1, IorD=1. Holds until mem_ready=1, then goes to FETCH with instr_done=1 in that cycle.
- WB_MEM: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Goes to FETCH.
- WB_ALU: RegWrite=1, MemtoReg=0, RegDst=(OP==0), instr_done=1. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=100, PCSource=01, instr_done=1. BranchEQ=(OP==0x04), BranchNE=(OP==0x05). Goes to FETCH.
- Output timing by signal type:
  - All controls are combinational from the state register, except the mem_ready-gated IRWrite/PCWrite, instr_done in MEM_WR, illegal_op, and the OP-dependent ALUOp, RegDst and Branch* outputs.
  - All controls are glitch-tolerant: the datapath samples them on clk.

## Timing
- Reset asserted (reset=0), asynchronously: state goes to IDLE and every output is 0 immediately.
- First FETCH is one cycle after reset deasserts.
- Latency with mem_ready held at 1:
  - R-type, I-type ALU: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branch: 3 cycles.
  - Illegal opcode: 2 cycles.
- Each cycle that mem_ready is low in FETCH, MEM_RD or MEM_WR adds one cycle.
- Reset mid-instruction abandons the instruction: no write enable stays asserted after reset, and no instr_done is issued.
- mem_ready is ignored in every state except FETCH, MEM_RD and MEM_WR.
- instr_done and illegal_op are never both high in the same cycle.

## Structure
- Shared package mips_pkg holds:
  - opcode localparams: R_TYPE, ADDI, ORI, ANDI, LUI, LW, SW, BEQ, BNE;
  - ALUOp encodings;
  - ALUSrcB and PCSource encodings;
  - the state encoding.
- Single sub-module mc_out_decode: combinational mapping of (state, OP, mem_ready) to outputs. The top module keeps only the state register and the next-state logic.

## Test plan
- Reset held low for 3 cycles, then released with mem_ready=1: all outputs 0 during reset; FETCH in cycle 1 with MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- OP=0x00, mem_ready=1: sequence FETCH, DECODE, EXEC_R (ALUOp=111), WB_ALU (RegWrite=1, RegDst=1, instr_done=1). Next instruction's FETCH in cycle 5.
- OP=0x23 with mem_ready low for 2 cycles in MEM_RD: MEM_RD lasts 3 cycles with IorD=1; then WB_MEM with MemtoReg=1, RegWrite=1. 7 cycles total.
- OP=0x05: BRANCH state with ALUOp=100, BranchNE=1, BranchEQ=0, PCSource=01; FETCH follows. Repeat with OP=0x04: BranchEQ=1, BranchNE=0.
- OP=0x3F: illegal_op=1 in DECODE only, no RegWrite or MemWrite, then FETCH. Also check OP=0x0F gives ALUOp=011 in EXEC_I.
- reset pulsed low mid-MEM_WR (SW, mem_ready=0): MemWrite drops to 0 asynchronously, no instr_done; on release, FETCH.
